// File: rtl/weight_mem_pkg.sv
// weight_mem_pkg: FSM state type, round-robin picker and saturating adder for weight_mem_arbiter.
package weight_mem_pkg;

   typedef enum logic [2:0] {IDLE, RD_RESP, WB_ACK, RMW_RD, RMW_WR} state_t;

   localparam int MAX_CH = 8;

   // Returns {found, index}; lowest offset from ptr wins, wrapping at n channels.
   function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] req, input logic [2:0] ptr, input int n);
      logic [3:0] r;
      logic [3:0] j;
      r = '0;
      for (int k = MAX_CH - 1; k >= 0; k--) begin
         j = {1'b0, ptr} + 4'(k);
         j = (j >= 4'(n)) ? j - 4'(n) : j;
         if (k < n && req[j[2:0]]) r = {1'b1, j[2:0]};
      end
      return r;
   endfunction

   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b, input int w);
      logic signed [31:0] s, hi, lo;
      s = a + b;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      return (s > hi) ? hi : (s < lo) ? lo : s;
   endfunction

endpackage

// File: rtl/weight_ram.sv
// weight_ram: single-port synchronous-read weight RAM, write-first, contents not reset.
module weight_ram #(
   parameter int ADDR_W = 4,
   parameter int DW = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DW-1:0]     wdata,
   output logic [DW-1:0]     rdata
);

   logic [DW-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= we ? wdata : mem[addr];
   end

endmodule

// File: rtl/weight_mem_arbiter.sv
// weight_mem_arbiter: host-load / multi-channel round-robin weight memory controller.
// Define WMA_RMW_EN to turn write-backs into saturating read-modify-write updates.
module weight_mem_arbiter
   import weight_mem_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DW = 8,
   parameter int NCH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  phase_infer,
   input  logic                  host_we,
   input  logic [ADDR_W-1:0]     host_addr,
   input  logic [DW-1:0]         host_wdata,
   input  logic [NCH-1:0]        rd_req,
   input  logic [NCH*ADDR_W-1:0] rd_addr,
   output logic [NCH-1:0]        rd_valid,
   output logic [DW-1:0]         rd_data,
   input  logic [NCH-1:0]        wb_req,
   input  logic [NCH*ADDR_W-1:0] wb_addr,
   input  logic [NCH*DW-1:0]     wb_data,
   output logic [NCH-1:0]        wb_ack,
   output logic                  busy
);

   state_t            state;
   logic [2:0]        rd_ptr, wb_ptr, g_q;
   logic [ADDR_W-1:0] addr_q, ram_addr, rd_a, wb_a;
   logic [DW-1:0]     ram_wd, ram_q, wb_d;
   logic              ram_we;
   logic [3:0]        rd_pick, wb_pick;

   function automatic logic [2:0] nxt(input logic [2:0] g);
      return (g == 3'(NCH - 1)) ? 3'd0 : g + 3'd1;
   endfunction

   assign rd_pick = rr_pick(MAX_CH'(rd_req), rd_ptr, NCH);
   assign wb_pick = rr_pick(MAX_CH'(wb_req), wb_ptr, NCH);
   assign rd_a = rd_addr[rd_pick[2:0]*ADDR_W +: ADDR_W];
   assign wb_a = wb_addr[wb_pick[2:0]*ADDR_W +: ADDR_W];
   assign wb_d = wb_data[((state == IDLE) ? wb_pick[2:0] : g_q)*DW +: DW];

   // Responses are suppressed the moment the phase drops, not one cycle later.
   assign rd_valid = (state == RD_RESP && phase_infer) ? NCH'(1'b1) << g_q : '0;
   assign wb_ack = (state == WB_ACK && phase_infer) ? NCH'(1'b1) << g_q : '0;
   assign rd_data = (|rd_valid) ? ram_q : '0;
   assign busy = (state != IDLE);

`ifdef WMA_RMW_EN
   logic [DW-1:0] rmw_wd;
   assign rmw_wd = DW'(sat_add(32'(signed'(ram_q)), 32'(signed'(wb_d)), DW));
`endif

   always_comb begin
      ram_we = 1'b0;
      ram_addr = addr_q;
      ram_wd = wb_d;
      if (!phase_infer) begin
         ram_we = host_we;
         ram_addr = host_addr;
         ram_wd = host_wdata;
      end else if (state == IDLE) begin
         ram_addr = wb_pick[3] ? wb_a : rd_a;
`ifndef WMA_RMW_EN
         ram_we = wb_pick[3];
`endif
      end
`ifdef WMA_RMW_EN
      else if (state == RMW_WR) begin
         ram_we = 1'b1;
         ram_wd = rmw_wd;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rd_ptr <= '0;
         wb_ptr <= '0;
         g_q <= '0;
         addr_q <= '0;
      end else if (!phase_infer) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (wb_pick[3]) begin
                  g_q <= wb_pick[2:0];
                  addr_q <= wb_a;
                  wb_ptr <= nxt(wb_pick[2:0]);
`ifdef WMA_RMW_EN
                  state <= RMW_RD;
`else
                  state <= WB_ACK;
`endif
               end else if (rd_pick[3]) begin
                  g_q <= rd_pick[2:0];
                  addr_q <= rd_a;
                  rd_ptr <= nxt(rd_pick[2:0]);
                  state <= RD_RESP;
               end
            end
`ifdef WMA_RMW_EN
            RMW_RD: state <= RMW_WR;
            RMW_WR: state <= WB_ACK;
`endif
            default: state <= IDLE;
         endcase
      end
   end

   weight_ram #(.ADDR_W(ADDR_W), .DW(DW)) u_ram (
      .clk(clk),
      .we(ram_we),
      .addr(ram_addr),
      .wdata(ram_wd),
      .rdata(ram_q)
   );

endmodule

// File: tb/tb_weight_mem_arbiter.sv
// tb_weight_mem_arbiter: table vectors, directed corner sequences and a random scoreboard run.
module tb_weight_mem_arbiter;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int NCH = 2;
`ifdef WMA_RMW_EN
   localparam int WB_LAT = 3;
`else
   localparam int WB_LAT = 1;
`endif

   logic clk = 1'b0, rst = 1'b1, phase_infer = 1'b0, host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic [NCH-1:0] rd_req = '0, wb_req = '0;
   logic [NCH*AW-1:0] rd_addr = '0, wb_addr = '0;
   logic [NCH*DW-1:0] wb_data = '0;
   logic [NCH-1:0] rd_valid, wb_ack;
   logic [DW-1:0] rd_data;
   logic busy;

   always #5 clk = ~clk;

   weight_mem_arbiter #(.ADDR_W(AW), .DW(DW), .NCH(NCH)) dut (
      .clk(clk), .rst(rst), .phase_infer(phase_infer),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
      .busy(busy)
   );

   int pass_cnt = 0, total_cnt = 0;
   logic [DW-1:0] mem_m [2**AW];

   typedef struct {
      int ch;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } vec_t;
   vec_t tbl [6];

   bit [NCH-1:0] rd_pend, wb_pend;
   logic [AW-1:0] rd_am [NCH];
   logic [AW-1:0] wb_am [NCH];
   logic [DW-1:0] wb_dm [NCH];
   int rd_age [NCH];
   int wb_age [NCH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_wb(input int a, input logic [DW-1:0] d);
`ifdef WMA_RMW_EN
      int s;
      s = int'($signed(mem_m[a])) + int'($signed(d));
      s = (s > 127) ? 127 : (s < -128) ? -128 : s;
      mem_m[a] = DW'(s);
`else
      mem_m[a] = d;
`endif
   endtask

   task automatic host_write(input int a, input logic [DW-1:0] d);
      host_we = 1'b1;
      host_addr = AW'(a);
      host_wdata = d;
      @(negedge clk);
      host_we = 1'b0;
      mem_m[a] = d;
   endtask

   task automatic wait_resp(output logic [NCH-1:0] v, output logic [NCH-1:0] a, output logic [DW-1:0] d, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rd_valid == '0 && wb_ack == '0 && n < 20);
      v = rd_valid;
      a = wb_ack;
      d = rd_data;
   endtask

   task automatic do_read(input int ch, input int a, input string name);
      logic [NCH-1:0] v, k;
      logic [DW-1:0] d;
      int n;
      rd_req[ch] = 1'b1;
      rd_addr[ch*AW +: AW] = AW'(a);
      wait_resp(v, k, d, n);
      chk({name, "_lat"}, n, 1);
      chk({name, "_valid"}, v, NCH'(1) << ch);
      chk({name, "_data"}, d, mem_m[a]);
      rd_req[ch] = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_wb(input int ch, input int a, input logic [DW-1:0] dat, input string name);
      logic [NCH-1:0] v, k;
      logic [DW-1:0] d;
      int n;
      wb_req[ch] = 1'b1;
      wb_addr[ch*AW +: AW] = AW'(a);
      wb_data[ch*DW +: DW] = dat;
      wait_resp(v, k, d, n);
      chk({name, "_lat"}, n, WB_LAT);
      chk({name, "_ack"}, k, NCH'(1) << ch);
      model_wb(a, dat);
      wb_req[ch] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [NCH-1:0] v, k;
      logic [DW-1:0] d;
      int n;
      bit prev_resp;
      tbl[0] = '{0, 4'd3, 8'h5A};
      tbl[1] = '{1, 4'd1, 8'h21};
      tbl[2] = '{0, 4'd2, 8'h42};
      tbl[3] = '{1, 4'd4, 8'hE0};
      tbl[4] = '{0, 4'd7, 8'h00};
      tbl[5] = '{1, 4'd15, 8'hFF};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_wb_ack", wb_ack, 0);
      chk("reset_rd_data", rd_data, 0);
      chk("reset_busy", busy, 0);

      // Load phase ignores requesters entirely.
      rd_req = '1;
      wb_req = '1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("load_ignore", {busy, rd_valid, wb_ack}, 0);
      end
      rd_req = '0;
      wb_req = '0;

      for (int i = 0; i < 6; i++) host_write(int'(tbl[i].addr), tbl[i].data);
      phase_infer = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rd_req[tbl[i].ch] = 1'b1;
         rd_addr[tbl[i].ch*AW +: AW] = tbl[i].addr;
         wait_resp(v, k, d, n);
         chk("tbl_lat", n, 1);
         chk("tbl_valid", v, NCH'(1) << tbl[i].ch);
         chk("tbl_data", d, tbl[i].data);
         rd_req = '0;
         @(negedge clk);
      end

      // Contention after reset: pointers at 0, so ch0 first, then alternate.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rd_addr = {4'd2, 4'd1};
      rd_req = 2'b11;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("cont_valid", rd_valid, (i % 2) ? 2'b00 : (i % 4 == 0) ? 2'b01 : 2'b10);
         if (i % 2 == 0) chk("cont_data", rd_data, (i % 4 == 0) ? mem_m[1] : mem_m[2]);
      end
      rd_req = '0;
      @(negedge clk);

      // Write-back beats a simultaneous read.
      rd_req[0] = 1'b1;
      rd_addr[0 +: AW] = 4'd3;
      wb_req[1] = 1'b1;
      wb_addr[AW +: AW] = 4'd4;
      wb_data[DW +: DW] = 8'h11;
      wait_resp(v, k, d, n);
      chk("prio_wb_lat", n, WB_LAT);
      chk("prio_wb_ack", k, 2'b10);
      chk("prio_no_rd", v, 2'b00);
      model_wb(4, 8'h11);
      wb_req = '0;
      wait_resp(v, k, d, n);
      chk("prio_rd_lat", n, 2);
      chk("prio_rd_valid", v, 2'b01);
      chk("prio_rd_data", d, mem_m[3]);
      rd_req = '0;
      @(negedge clk);
      do_read(0, 4, "prio_check");

      do_wb(1, 7, 8'hC3, "wbr_wb");
      do_read(0, 7, "wbr_rd");

      // Phase drop while a read response is due.
      rd_req[0] = 1'b1;
      rd_addr[0 +: AW] = 4'd3;
      @(negedge clk);
      chk("drop_busy_pre", busy, 1);
      phase_infer = 1'b0;
      rd_req = '0;
      host_we = 1'b1;
      host_addr = 4'd9;
      host_wdata = 8'h77;
      #1;
      chk("drop_no_valid", rd_valid, 0);
      @(negedge clk);
      mem_m[9] = 8'h77;
      host_we = 1'b0;
      chk("drop_busy", busy, 0);
      chk("drop_no_valid2", rd_valid, 0);
      phase_infer = 1'b1;
      do_read(0, 9, "drop_host");

`ifdef WMA_RMW_EN
      phase_infer = 1'b0;
      host_write(2, 8'h7E);
      phase_infer = 1'b1;
      do_wb(0, 2, 8'h05, "rmw_pos");
      do_read(0, 2, "rmw_pos_rd");
      chk("rmw_pos_sat", mem_m[2], 8'h7F);
      phase_infer = 1'b0;
      host_write(2, 8'h80);
      phase_infer = 1'b1;
      do_wb(1, 2, 8'hFF, "rmw_neg");
      do_read(0, 2, "rmw_neg_rd");
      chk("rmw_neg_sat", mem_m[2], 8'h80);
`endif

      // Random traffic against a serialising memory scoreboard.
      phase_infer = 1'b0;
      for (int a = 0; a < 2**AW; a++) host_write(a, DW'($urandom));
      phase_infer = 1'b1;
      rd_pend = '0;
      wb_pend = '0;
      prev_resp = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         rd_age[c] = 0;
         wb_age[c] = 0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if ((rd_valid | wb_ack) != '0) begin
            chk("rnd_onehot", $countones(rd_valid | wb_ack), 1);
            chk("rnd_gap", prev_resp, 0);
         end
         prev_resp = ((rd_valid | wb_ack) != '0);
         for (int c = 0; c < NCH; c++) begin
            if (rd_valid[c]) begin
               chk("rnd_rd_pend", rd_pend[c], 1);
               chk("rnd_rd_data", rd_data, mem_m[rd_am[c]]);
               rd_pend[c] = 1'b0;
               rd_req[c] = 1'b0;
            end
            if (wb_ack[c]) begin
               chk("rnd_wb_pend", wb_pend[c], 1);
               model_wb(int'(wb_am[c]), wb_dm[c]);
               wb_pend[c] = 1'b0;
               wb_req[c] = 1'b0;
            end
            rd_age[c] = rd_pend[c] ? rd_age[c] + 1 : 0;
            wb_age[c] = wb_pend[c] ? wb_age[c] + 1 : 0;
            if (rd_age[c] > 300 || wb_age[c] > 300) begin
               chk("rnd_starve", rd_age[c] + wb_age[c], 0);
               $fatal(1, "starved channel, aborting");
            end
            if (!rd_pend[c] && $urandom_range(0, 1) == 1) begin
               rd_pend[c] = 1'b1;
               rd_am[c] = AW'($urandom);
               rd_addr[c*AW +: AW] = rd_am[c];
               rd_req[c] = 1'b1;
            end
            if (!wb_pend[c] && $urandom_range(0, 7) == 0) begin
               wb_pend[c] = 1'b1;
               wb_am[c] = AW'($urandom);
               wb_dm[c] = DW'($urandom);
               wb_addr[c*AW +: AW] = wb_am[c];
               wb_data[c*DW +: DW] = wb_dm[c];
               wb_req[c] = 1'b1;
            end
         end
      end
      rd_req = '0;
      wb_req = '0;
      @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/weight_mem_arbiter.md
Name: weight_mem_arbiter

Overview:
- Parametrised weight-memory controller for the SNN core.
- Owns the synchronous-read weight RAM. Accepts host weight loads in load phase (phase_infer=0). Arbitrates read and write-back requests from NCH layer engines in inference phase (phase_infer=1).
- Successor to the single-requester read/write-back pipeline in the top level. Adds multiple channels, round-robin fairness, a busy flag, and an optional read-modify-write learning update.

Parameters:
- ADDR_W, 4: weight address width; RAM depth = 2**ADDR_W.
- DW, 8: weight width in bits; signed two's complement when WMA_RMW_EN is defined.
- NCH, 2: number of requester channels, 1..8.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- phase_infer  in  1  0 = host load phase, 1 = inference/learning phase.
- host_we  in  1  host write strobe; honoured only when phase_infer=0.
- host_addr  in  ADDR_W  host write address.
- host_wdata  in  DW  host write data.
- rd_req  in  NCH  per-channel read request; level, held until rd_valid.
- rd_addr  in  NCH*ADDR_W  per-channel read address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- rd_valid  out  NCH  one-hot, single-cycle read response.
- rd_data  out  DW  read data, shared by all channels; qualified by rd_valid.
- wb_req  in  NCH  per-channel write-back request; level, held until wb_ack.
- wb_addr  in  NCH*ADDR_W  per-channel write-back address.
- wb_data  in  NCH*DW  write-back data, or signed delta when WMA_RMW_EN is defined.
- wb_ack  out  NCH  one-hot, single-cycle write-back completion.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; rd_valid=0, wb_ack=0, rd_data=0, busy=0.
  - Both round-robin pointers reset to 0.
  - RAM contents are not cleared.
- Load phase (phase_infer=0):
  - host_we=1 writes RAM[host_addr] <= host_wdata in the same edge.
  - FSM is held in IDLE. rd_req and wb_req are ignored, and no valid or ack is produced.
  - Back-to-back host writes run one per cycle.
- Inference phase, FSM states:
  - IDLE: sample requests.
    - Write-back has priority over read.
    - Within a class, round-robin starts at that class's pointer.
    - Grant W: RAM[wb_addr[g]] <= wb_data[g]; go to WB_ACK.
    - Grant R: latch the address; RAM read issued; go to RD_RESP.
    - Granted class pointer <= (g+1) mod NCH. The other class pointer is unchanged.
  - RD_RESP: rd_valid[g]=1 and rd_data = RAM value, for exactly one cycle; go to IDLE.
  - WB_ACK: wb_ack[g]=1 for exactly one cycle; go to IDLE.
- Latency:
  - Read: request seen in IDLE at cycle t, response at cycle t+1.
  - Write-back: ack at cycle t+1.
  - Sustained throughput is one operation per 2 cycles.
- Requests are sampled only in IDLE. A requester must hold req/addr/data stable until its response. A req dropped early is undefined.
- A channel may assert rd_req and wb_req together; its write-back is served first.
- Read after write-back to the same address returns the new value, because there is only one op outstanding.
- phase_infer falling mid-operation:
  - FSM goes to IDLE at the next edge; no valid or ack is emitted.
  - A completed RAM write stays; a pending RMW write is discarded.
  - Pointers are kept.
- Out-of-range addresses cannot occur, since addresses are exactly ADDR_W bits.

Optional Feature:
- Macro WMA_RMW_EN.
- Defined: a write-back becomes a read-modify-write.
  - Path: IDLE -> RMW_RD (RAM read) -> RMW_WR (RAM[a] <= sat(old + delta)) -> WB_ACK.
  - Arithmetic: signed DW-bit add, saturated to [-2**(DW-1), 2**(DW-1)-1].
  - Ack latency is 3 cycles.
- Undefined: write-back is a plain overwrite with 1-cycle ack. RMW states and the adder are not built.

Decomposition:
- Package weight_mem_pkg holds:
  - the state enum (IDLE, RD_RESP, WB_ACK, RMW_RD, RMW_WR);
  - a rr_pick function (request vector, pointer) -> {found, index};
  - a saturating-add function.
- One sub-module, weight_ram (ADDR_W, DW): single port, synchronous read, write-first.

Test Plan:
- Host load: phase_infer=0, write addr 3 = 8'h5A, then phase_infer=1, ch0 reads addr 3 -> rd_valid=2'b01 one cycle later, rd_data=8'h5A.
- Contention (NCH=2): both channels rd_req held, addrs 1 and 2 -> responses alternate ch0, ch1, ch0…, one every 2 cycles, with no starvation.
- Priority: ch0 rd_req and ch1 wb_req (addr 4, data 8'h11) together -> wb_ack[1] first, then rd_valid[0].
- Write-back then read: ch1 wb addr 7 = 8'hC3, then ch0 reads addr 7 -> rd_data=8'hC3.
- Phase drop: ch0 read granted, phase_infer=0 at the RD_RESP edge -> no rd_valid, busy=0; host write in the same cycle lands.
- RMW (macro defined, DW=8): addr 2 = 8'h7E, delta 8'h05 -> stored 8'h7F, wb_ack at t+3; addr 2 = 8'h80, delta 8'hFF -> stays 8'h80.
